radiant_scaler_conditioner: RTL and testbench
=============================================

// Module: radiant_scaler_conditioner
// PURPOSE
//  Conditions raw trigger/discriminator levels into single-cycle count pulses for the prescaled scaler bank.
//  Per channel: 2-FF synchronizer, rising-edge detect, programmable holdoff (dead time), enable mask.
//  Runs in the sys_clk_i domain; count_o drives the scaler bank's scal_i directly.
//  A global saturating counter of cycles with suppressed edges is kept for diagnostics.
// PARAMETERS
//  NUM_CH        32  number of channels (1..64)
//  HOLDOFF_BITS  8   width of per-channel holdoff count, in sys_clk_i cycles
//  DROP_BITS     16  width of drop_cycles_o saturating counter
// PORTS
//  sys_clk_i      in   1             sole clock (scaler fast clock)
//  sys_rst_ni     in   1             asynchronous active-low reset
//  trig_i         in   NUM_CH        raw asynchronous trigger levels
//  cfg_wr_i       in   1             1-cycle strobe: write holdoff of channel cfg_ch_i
//  cfg_ch_i       in   6             channel index for cfg_wr_i (>= NUM_CH ignored)
//  cfg_holdoff_i  in   HOLDOFF_BITS  holdoff value to write
//  ch_en_i        in   NUM_CH        per-channel enable mask, level
//  drop_clr_i     in   1             1-cycle strobe: clear drop_cycles_o
//  count_o        out  NUM_CH        1-cycle count pulses to scaler bank
//  drop_cycles_o  out  DROP_BITS     cycles in which >=1 enabled edge was suppressed
// BEHAVIOUR
//  - Reset (async assert, sync release internally not required): sync FFs, edge regs, holdoff counters,
//    holdoff config regs, count_o, drop_cycles_o all 0.
//  - Pipeline per channel: s0 <= trig_i; s1 <= s0; s2 <= s1; edge = s1 & ~s2.
//  - Accept: edge & ch_en_i[c] & (hcnt[c]==0). On accept: count_o[c] <= 1 next cycle, hcnt[c] <= holdoff[c].
//  - Latency: trig_i high sampled into s0 at edge N -> count_o[c] high during cycle N+3, exactly one cycle.
//  - Holdoff: hcnt!=0 decrements by 1 each cycle; edges seen while hcnt!=0 are suppressed (never deferred).
//    holdoff=H -> after an accepted edge, next edge acceptable >= H+1 cycles after accept cycle.
//    H=0 -> no dead time; max rate limited by edge detect to one pulse per 2 cycles.
//  - Config write: holdoff[c] updated next cycle; an active hcnt is not reloaded or truncated;
//    new value applies to the next accept. Write to the same channel as a same-cycle accept loads the OLD value.
//  - Mask: ch_en_i[c]=0 -> edges ignored (not counted as drops), hcnt[c] forced to 0, count_o[c]=0.
//    Sync pipeline keeps running so re-enable never produces a stale edge older than 2 cycles.
//  - Input held high: exactly one pulse. Level toggling faster than sampling is undefined (async source).
//  - drop_cycles_o: +1 in any cycle where >=1 enabled channel has edge & hcnt!=0 (not per-channel sum).
//    Saturates at all-ones, no wrap. drop_clr_i wins over same-cycle increment (result 0).
//  - Reset asserted mid-holdoff: all counters 0 immediately; first edge after release accepted.
// CONFIGURATION
//  `SCALER_COND_GLITCH_FILTER_EN defined: extra stage s3; edge = s1 & s2 & ~s3 (input must be high
//   2 consecutive samples); single-sample highs produce no pulse; latency becomes N+4.
//  Undefined: no s3, edge = s1 & ~s2, latency N+3, 1-sample highs counted.
// STRUCTURE
//  Package radiant_scaler_pkg: localparams HOLDOFF_BITS_DEFAULT, DROP_BITS_DEFAULT, CH_IDX_BITS(=6);
//   typedef holdoff_t (logic [HOLDOFF_BITS-1:0]), typedef ch_idx_t.
//  Sub-module radiant_scaler_cond_chan: one channel (sync, edge, holdoff reg+counter, accept/drop flags);
//   top generates NUM_CH instances, decodes cfg_wr_i, ORs drop flags into the drop counter.
// TESTING
//  1. trig_i[0] 0->1 held 20 cycles, holdoff=0, en=1 -> count_o[0] one pulse at N+3, no others.
//  2. holdoff[5]=10, edges on ch5 every 4 cycles x6 -> pulses at 1st and 4th edges only (gap 12 >= 11);
//     drop_cycles_o=4.
//  3. holdoff=0, trig toggling every cycle on ch1 -> pulse every 2 cycles, drop_cycles_o stays 0.
//  4. ch_en_i[2]=0 during edge on ch2 -> no pulse, drop unchanged; re-enable with trig high -> no pulse.
//  5. drop_cycles_o preloaded to 0xFFFF by drop burst -> further drops hold 0xFFFF; drop_clr_i with
//     same-cycle drop -> 0.
//  6. sys_rst_ni low for 3 cycles while hcnt[0]=200 -> all outputs 0; edge 5 cycles after release -> pulse.
//     With SCALER_COND_GLITCH_FILTER_EN: 1-cycle high on ch3 -> no pulse; 2-cycle high -> pulse at N+4.

Source files
------------

// File: rtl/radiant_scaler_pkg.sv
// Shared types and defaults for the radiant scaler input conditioner.
package radiant_scaler_pkg;

    localparam int HOLDOFF_BITS_DEFAULT = 8;
    localparam int DROP_BITS_DEFAULT    = 16;
    localparam int CH_IDX_BITS          = 6;

    typedef logic [HOLDOFF_BITS_DEFAULT-1:0] holdoff_t;
    typedef logic [CH_IDX_BITS-1:0]          ch_idx_t;

endpackage

// File: rtl/radiant_scaler_cond_chan.sv
// One conditioner channel: 2-FF synchronizer, rising-edge detect, holdoff dead time and enable mask.
// Build option: SCALER_COND_GLITCH_FILTER_EN adds a third stage so an edge needs two consecutive high samples.
module radiant_scaler_cond_chan
    import radiant_scaler_pkg::*;
#(
    parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trig,
    input  logic                    en,
    input  logic                    cfg_wr,
    input  logic [HOLDOFF_BITS-1:0] cfg_holdoff,
    output logic                    count,
    output logic                    drop
);

    localparam logic [HOLDOFF_BITS-1:0] HCNT_ONE = {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};

    logic                    s0_reg, s1_reg, s2_reg;
    logic                    edge_det;
    logic                    busy;
    logic                    accept;
    logic                    count_reg;
    logic [HOLDOFF_BITS-1:0] holdoff_reg;
    logic [HOLDOFF_BITS-1:0] hcnt_reg;

`ifdef SCALER_COND_GLITCH_FILTER_EN
    logic s3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3_reg <= 1'b0;
        else        s3_reg <= s2_reg;
    end

    assign edge_det = s1_reg & s2_reg & ~s3_reg;
`else
    assign edge_det = s1_reg & ~s2_reg;
`endif

    // The synchronizer keeps running while masked so re-enabling never sees a stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_reg <= 1'b0;
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s0_reg <= trig;
            s1_reg <= s0_reg;
            s2_reg <= s1_reg;
        end
    end

    assign busy   = (hcnt_reg != '0);
    assign accept = edge_det & en & ~busy;
    assign drop   = edge_det & en & busy;

    // An accept in the same cycle as a config write loads the old holdoff value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff_reg <= '0;
            hcnt_reg    <= '0;
            count_reg   <= 1'b0;
        end else begin
            count_reg <= accept;
            if (cfg_wr)
                holdoff_reg <= cfg_holdoff;
            if (!en)
                hcnt_reg <= '0;
            else if (accept)
                hcnt_reg <= holdoff_reg;
            else if (busy)
                hcnt_reg <= hcnt_reg - HCNT_ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/radiant_scaler_conditioner.sv
// Conditions raw trigger levels into single-cycle count pulses for the scaler bank, with a drop-cycle counter.
// Build option: SCALER_COND_GLITCH_FILTER_EN (per-channel two-sample glitch filter, latency +1).
module radiant_scaler_conditioner
    import radiant_scaler_pkg::*;
#(
    parameter int NUM_CH       = 32,
    parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEFAULT,
    parameter int DROP_BITS    = DROP_BITS_DEFAULT
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_ni,
    input  logic [NUM_CH-1:0]       trig_i,
    input  logic                    cfg_wr_i,
    input  ch_idx_t                 cfg_ch_i,
    input  logic [HOLDOFF_BITS-1:0] cfg_holdoff_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic                    drop_clr_i,
    output logic [NUM_CH-1:0]       count_o,
    output logic [DROP_BITS-1:0]    drop_cycles_o
);

    localparam logic [DROP_BITS-1:0] DROP_ONE = {{(DROP_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0]    drop_flags;
    logic [NUM_CH-1:0]    cfg_sel;
    logic                 drop_any;
    logic [DROP_BITS-1:0] drop_cycles_reg;

    // Out-of-range channel indices match no instance and are silently ignored.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign cfg_sel[gi] = cfg_wr_i && (cfg_ch_i == ch_idx_t'(gi));

            radiant_scaler_cond_chan #(
                .HOLDOFF_BITS (HOLDOFF_BITS)
            ) u_chan (
                .clk         (sys_clk_i),
                .rst_n       (sys_rst_ni),
                .trig        (trig_i[gi]),
                .en          (ch_en_i[gi]),
                .cfg_wr      (cfg_sel[gi]),
                .cfg_holdoff (cfg_holdoff_i),
                .count       (count_o[gi]),
                .drop        (drop_flags[gi])
            );
        end
    endgenerate

    assign drop_any = |drop_flags;

    // Counts cycles, not channels; clear beats a same-cycle increment.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni)
            drop_cycles_reg <= '0;
        else if (drop_clr_i)
            drop_cycles_reg <= '0;
        else if (drop_any && (drop_cycles_reg != '1))
            drop_cycles_reg <= drop_cycles_reg + DROP_ONE;
    end

    assign drop_cycles_o = drop_cycles_reg;

endmodule

// File: tb/tb_radiant_scaler_conditioner.sv
// Directed plus randomized bench for radiant_scaler_conditioner against a timestamp-based reference model.
// Honours SCALER_COND_GLITCH_FILTER_EN in the same way as the design.
module tb_radiant_scaler_conditioner;

    localparam int NUM_CH = 8;
    localparam int HB     = 8;
    localparam int DB     = 6;
    localparam int DMAX   = (1 << DB) - 1;
`ifdef SCALER_COND_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_CH-1:0] trig = '0;
    logic              cfg_wr = 1'b0;
    logic [5:0]        cfg_ch = '0;
    logic [HB-1:0]     cfg_hold = '0;
    logic [NUM_CH-1:0] en = '0;
    logic              drop_clr = 1'b0;
    logic [NUM_CH-1:0] count_o;
    logic [DB-1:0]     drop_cycles_o;

    radiant_scaler_conditioner #(
        .NUM_CH       (NUM_CH),
        .HOLDOFF_BITS (HB),
        .DROP_BITS    (DB)
    ) dut (
        .sys_clk_i     (clk),
        .sys_rst_ni    (rst_n),
        .trig_i        (trig),
        .cfg_wr_i      (cfg_wr),
        .cfg_ch_i      (cfg_ch),
        .cfg_holdoff_i (cfg_hold),
        .ch_en_i       (en),
        .drop_clr_i    (drop_clr),
        .count_o       (count_o),
        .drop_cycles_o (drop_cycles_o)
    );

    always #5 clk = ~clk;

    // Reference model: sampled-input history, and per channel the first cycle an edge may be accepted.
    logic [NUM_CH-1:0] hist[$];
    int                cyc;
    int                next_ok[NUM_CH];
    int                hold[NUM_CH];
    int                pulses[NUM_CH];
    logic [NUM_CH-1:0] exp_count;
    int                exp_drop;
    int                n_pass = 0;
    int                n_checks = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            next_ok[c] = 0;
            hold[c]    = 0;
        end
        exp_count = '0;
        exp_drop  = 0;
        repeat (4) hist.push_back('0);
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic step();
        logic [NUM_CH-1:0] s1, s2, edg;
        int n;
        bit drop_any, ok, acc;
        n  = hist.size();
        s1 = hist[n-2];
        s2 = hist[n-3];
`ifdef SCALER_COND_GLITCH_FILTER_EN
        edg = s1 & s2 & ~hist[n-4];
`else
        edg = s1 & ~s2;
`endif
        drop_any = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ok  = (cyc >= next_ok[c]);
            acc = edg[c] && en[c] && ok;
            exp_count[c] = acc;
            if (edg[c] && en[c] && !ok) drop_any = 1'b1;
            if (acc)
                next_ok[c] = cyc + 1 + hold[c];
            else if (!en[c] && next_ok[c] > cyc + 1)
                next_ok[c] = cyc + 1;
        end
        if (cfg_wr && cfg_ch < NUM_CH) hold[cfg_ch] = int'(cfg_hold);
        if (drop_clr) exp_drop = 0;
        else if (drop_any && exp_drop < DMAX) exp_drop++;
        hist.push_back(trig);
        while (hist.size() > 8) void'(hist.pop_front());
        @(posedge clk);
        cyc++;
        #1;
        for (int c = 0; c < NUM_CH; c++) pulses[c] += int'(count_o[c]);
        check("count", longint'(count_o), longint'(exp_count));
        check("drop", longint'(drop_cycles_o), longint'(exp_drop));
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_count", longint'(count_o), 0);
        check("rst_drop", longint'(drop_cycles_o), 0);
        repeat (ncyc) begin
            @(posedge clk);
            cyc++;
            hist.push_back('0);
            while (hist.size() > 8) void'(hist.pop_front());
            #1;
            check("rst_count", longint'(count_o), 0);
            check("rst_drop", longint'(drop_cycles_o), 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int val);
        cfg_wr   = 1'b1;
        cfg_ch   = 6'(ch);
        cfg_hold = HB'(val);
        step();
        cfg_wr   = 1'b0;
    endtask

    initial begin
        int t0, pcyc, p0, d0;
        cyc = 0;
        for (int c = 0; c < NUM_CH; c++) pulses[c] = 0;
        #2;
        do_reset(3);
        en = '1;
        repeat (3) step();

        // 1: held level, holdoff 0 -> one pulse at fixed latency
        t0 = cyc; pcyc = -1; p0 = pulses[0];
        trig[0] = 1'b1;
        repeat (20) begin
            step();
            if (count_o[0] && pcyc < 0) pcyc = cyc;
        end
        check("t1_pulses", pulses[0] - p0, 1);
        check("t1_latency", pcyc - t0, LAT);
        trig[0] = 1'b0;
        repeat (4) step();

        // 2: holdoff 10, edges every 4 cycles x6
        cfg_write(5, 10);
        p0 = pulses[5]; d0 = int'(drop_cycles_o);
        repeat (6) begin
            trig[5] = 1'b1; repeat (2) step();
            trig[5] = 1'b0; repeat (2) step();
        end
        repeat (4) step();
        check("t2_pulses", pulses[5] - p0, 2);
        check("t2_drops", int'(drop_cycles_o) - d0, 4);
        repeat (12) step();

        // 3: holdoff 0, trig toggling every cycle
        p0 = pulses[1]; d0 = int'(drop_cycles_o);
        for (int i = 0; i < 12; i++) begin
            trig[1] = ~trig[1];
            step();
        end
        trig[1] = 1'b0;
        repeat (4) step();
        check("t3_pulses", pulses[1] - p0, 6);
        check("t3_drops", int'(drop_cycles_o) - d0, 0);

        // 4: masked edge ignored; re-enable with level high gives nothing
        p0 = pulses[2]; d0 = int'(drop_cycles_o);
        en[2] = 1'b0; trig[2] = 1'b1;
        repeat (6) step();
        en[2] = 1'b1;
        repeat (6) step();
        check("t4_pulses", pulses[2] - p0, 0);
        check("t4_drops", int'(drop_cycles_o) - d0, 0);
        trig[2] = 1'b0;
        repeat (3) step();

        // 5: saturate the drop counter, then clear during a drop cycle
        cfg_write(6, 255);
        cfg_write(7, 255);
        for (int i = 0; i < 90; i++) begin
            trig[6] = ~trig[6];
            trig[7] = ~trig[6];
            step();
        end
        check("t5_sat", longint'(drop_cycles_o), DMAX);
        drop_clr = 1'b1;
        trig[6] = ~trig[6]; trig[7] = ~trig[6];
        step();
        drop_clr = 1'b0;
        check("t5_clr", longint'(drop_cycles_o), 0);
        trig[6] = 1'b0; trig[7] = 1'b0;
        repeat (3) step();

        // 6: reset in the middle of a long holdoff
        cfg_write(0, 200);
        trig[0] = 1'b1;
        repeat (6) step();
        trig[0] = 1'b0;
        repeat (2) step();
        do_reset(3);
        repeat (5) step();
        p0 = pulses[0];
        trig[0] = 1'b1;
        repeat (6) step();
        check("t6_pulses", pulses[0] - p0, 1);
        trig[0] = 1'b0;
        repeat (3) step();

`ifdef SCALER_COND_GLITCH_FILTER_EN
        p0 = pulses[3];
        trig[3] = 1'b1; step();
        trig[3] = 1'b0; repeat (6) step();
        check("gf_single", pulses[3] - p0, 0);
        trig[3] = 1'b1; repeat (2) step();
        trig[3] = 1'b0; repeat (6) step();
        check("gf_double", pulses[3] - p0, 1);
`endif

        // Randomized traffic, including out-of-range config writes
        for (int i = 0; i < 500; i++) begin
            trig     = NUM_CH'($urandom);
            en       = NUM_CH'($urandom | $urandom);
            cfg_wr   = ($urandom_range(0, 5) == 0);
            cfg_ch   = 6'($urandom_range(0, 9));
            cfg_hold = HB'($urandom_range(0, 6));
            drop_clr = ($urandom_range(0, 30) == 0);
            step();
        end
        cfg_wr = 1'b0; drop_clr = 1'b0; trig = '0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
